audio_output_stage: RTL and testbench

Final audio stage after the analog sound mixer. Takes the mixer's 16-bit unsigned output sampled at the 3 MHz enable and decimates it by boxcar averaging. It removes DC with a first-order high-pass, applies a click-free mute ramp and a 2-bit volume attenuation, then saturates. It presents signed 16-bit samples with a one-cycle valid strobe to the audio DAC/HDMI path.

---
 rtl/audio_output_stage.sv | 177 +++++++++++++++++
 tb/tb_audio_output_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_output_stage.sv
// Final audio stage: boxcar decimation, DC-blocking high-pass, click-free mute
// ramp with 2-bit volume, and signed 16-bit output with a one-cycle strobe.
module audio_output_stage #(
   parameter int DECIM_LOG2 = 6,
   parameter int DC_SHIFT   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_3MHz_en,
   input  logic [15:0] in,
   input  logic        mute,
   input  logic [1:0]  vol,
   output logic [15:0] out,
   output logic        out_valid,
   output logic        muted
);

   localparam int AW = 16 + DECIM_LOG2;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      ACTIVE    = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_t;

   // Stage 0: accumulator and window counter
   logic [AW-1:0]         acc;
   logic [AW-1:0]         acc_sum;
   logic [DECIM_LOG2-1:0] cnt;
   logic [15:0]           avg;
   logic                  avg_valid;

   assign acc_sum = acc + {{DECIM_LOG2{1'b0}}, in};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         avg       <= '0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         if (clk_3MHz_en) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
               avg       <= acc_sum[AW-1:DECIM_LOG2];
               acc       <= '0;
               avg_valid <= 1'b1;
            end else begin
               acc <= acc_sum;
            end
         end
      end
   end

   // Stages 1-2: signed conversion and DC block at 18-bit width
   logic signed [15:0] x;
   logic signed [15:0] x_prev;
   logic signed [15:0] y_prev;
   logic               y_valid;
   logic signed [17:0] x_ext;
   logic signed [17:0] xp_ext;
   logic signed [17:0] yp_ext;
   logic signed [17:0] leak;
   logic signed [17:0] y_full;
   logic signed [15:0] y_sat;

   assign x      = $signed(avg ^ 16'h8000);
   assign x_ext  = {{2{x[15]}}, x};
   assign xp_ext = {{2{x_prev[15]}}, x_prev};
   assign yp_ext = {{2{y_prev[15]}}, y_prev};
   assign leak   = yp_ext >>> DC_SHIFT;
   assign y_full = x_ext - xp_ext + yp_ext - leak;

   always_comb begin
      y_sat = y_full[15:0];
      if (y_full > 18'sd32767) begin
         y_sat = 16'sh7FFF;
      end else if (y_full < -18'sd32768) begin
         y_sat = 16'sh8000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_prev  <= '0;
         y_prev  <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= avg_valid;
         if (avg_valid) begin
            x_prev <= x;
            y_prev <= y_sat;
         end
      end
   end

   // Stage 3: ramp FSM, gain multiply and volume shift
   ramp_state_t state;
   ramp_state_t state_next;
   logic [8:0]  gain;
   logic [8:0]  gain_next;

   always_comb begin
      state_next = state;
      gain_next  = gain;
      unique case (state)
         MUTED: begin
            if (!mute) begin
               state_next = RAMP_UP;
               gain_next  = 9'd1;
            end
         end
         RAMP_UP: begin
            if (mute) begin
               gain_next  = gain - 9'd1;
               state_next = (gain == 9'd1) ? MUTED : RAMP_DOWN;
            end else begin
               gain_next = gain + 9'd1;
               if (gain == 9'd255) state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if (mute) begin
               state_next = RAMP_DOWN;
               gain_next  = 9'd255;
            end
         end
         RAMP_DOWN: begin
            if (!mute) begin
               gain_next  = gain + 9'd1;
               state_next = (gain == 9'd255) ? ACTIVE : RAMP_UP;
            end else begin
               gain_next = gain - 9'd1;
               if (gain == 9'd1) state_next = MUTED;
            end
         end
         default: begin
            state_next = MUTED;
            gain_next  = 9'd0;
         end
      endcase
   end

   logic signed [25:0] y_ext26;
   logic signed [25:0] g_ext26;
   logic signed [25:0] prod;
   logic signed [25:0] scaled;
   logic signed [25:0] shifted;

   assign y_ext26 = {{10{y_prev[15]}}, y_prev};
   assign g_ext26 = {17'd0, gain_next};
   assign prod    = y_ext26 * g_ext26;
   assign scaled  = prod >>> 8;
   // ~vol equals 3 - vol for a 2-bit value
   assign shifted = scaled >>> (~vol);

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         state     <= MUTED;
         gain      <= '0;
      end else begin
         out_valid <= y_valid;
         if (y_valid) begin
            out   <= shifted[15:0];
            state <= state_next;
            gain  <= gain_next;
         end
      end
   end

   assign muted = (state == MUTED);

endmodule

// File: tb/tb_audio_output_stage.sv
// Bench for audio_output_stage: directed windows against a per-window
// arithmetic model, plus literal expectations for key samples.
module tb_audio_output_stage;

   localparam int DL = 3;
   localparam int WIN = 1 << DL;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] din;
   logic        mute;
   logic [1:0]  vol;
   logic [15:0] out;
   logic        out_valid;
   logic        muted;

   audio_output_stage #(.DECIM_LOG2(DL), .DC_SHIFT(10)) dut (
      .clk(clk), .rst(rst), .clk_3MHz_en(en), .in(din), .mute(mute),
      .vol(vol), .out(out), .out_valid(out_valid), .muted(muted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic rst_d = 1'b1;

   // model state
   int m_sum = 0, m_n = 0, m_xp = 0, m_yp = 0, m_g = 0;
   int          due_q[$];
   logic [15:0] exp_q[$];
   logic        expm_q[$];

   always @(posedge clk) begin
      int avg, x, y, p, o;
      rst_d = rst;
      if (rst) begin
         m_sum = 0; m_n = 0; m_xp = 0; m_yp = 0; m_g = 0;
         due_q.delete(); exp_q.delete(); expm_q.delete();
      end else if (en) begin
         m_sum += int'(din);
         m_n++;
         if (m_n == WIN) begin
            avg = m_sum / WIN;
            x = avg - 32768;
            y = x - m_xp + m_yp - (m_yp >>> 10);
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            m_xp = x;
            m_yp = y;
            if (mute) m_g = (m_g > 0) ? m_g - 1 : 0;
            else      m_g = (m_g < 256) ? m_g + 1 : 256;
            p = (y * m_g) >>> 8;
            o = p >>> (3 - int'(vol));
            due_q.push_back(cyc + 3);
            exp_q.push_back(16'(o));
            expm_q.push_back(m_g == 0);
            m_sum = 0;
            m_n = 0;
         end
      end
      cyc++;
   end

   // compare process
   logic [15:0] exp_out = 16'd0;
   logic        exp_muted = 1'b1;
   int strobe_cnt = 0, strobe_cyc = 0, spacing = 0;
   logic [15:0] last_val = 16'd0;
   logic        last_muted = 1'b1;

   always @(negedge clk) begin
      logic exp_v;
      if (cyc > 0) begin
         if (rst_d) begin
            exp_out = 16'd0;
            exp_muted = 1'b1;
         end
         exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
         if (exp_v) begin
            void'(due_q.pop_front());
            exp_out = exp_q.pop_front();
            exp_muted = expm_q.pop_front();
         end
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
         end
         checks++;
         if (out !== exp_out) begin
            errors++;
            $display("FAIL out cyc=%0d got=%0d want=%0d", cyc, $signed(out), $signed(exp_out));
         end
         checks++;
         if (muted !== exp_muted) begin
            errors++;
            $display("FAIL muted cyc=%0d got=%b want=%b", cyc, muted, exp_muted);
         end
         if (out_valid === 1'b1) begin
            strobe_cnt++;
            spacing = cyc - strobe_cyc;
            strobe_cyc = cyc;
            last_val = out;
            last_muted = muted;
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic send_enable(input logic [15:0] v);
      @(posedge clk); #1 en = 1'b1; din = v;
      @(posedge clk); #1 en = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic send_window(input logic [15:0] v);
      for (int i = 0; i < WIN; i++) send_enable(v);
   endtask

   task automatic wait_strobe(input int n0);
      int k;
      k = 0;
      while (strobe_cnt == n0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      if (strobe_cnt == n0) begin
         errors++;
         checks++;
         $display("FAIL strobe_timeout got=none want=strobe");
      end
   endtask

   task automatic window_wait(input logic [15:0] v, output logic [15:0] val);
      int n0;
      n0 = strobe_cnt;
      send_window(v);
      wait_strobe(n0);
      val = last_val;
   endtask

   logic [15:0] v;
   int n0, en_cyc;

   initial begin
      rst = 1'b1; en = 1'b0; din = 16'd0; mute = 1'b0; vol = 2'd3;
      // reset with random input activity
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 din = 16'($urandom_range(0, 65535)); en = (i % 4 == 0);
      end
      @(posedge clk); #1;
      chk("reset_out", int'(out), 0);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_muted", int'(muted), 1);
      rst = 1'b0; en = 1'b0;

      // midscale: first window with latency measurement
      n0 = strobe_cnt;
      for (int i = 0; i < WIN - 1; i++) send_enable(16'h8000);
      @(posedge clk); #1 en = 1'b1; din = 16'h8000; en_cyc = cyc;
      @(posedge clk); #1 en = 1'b0;
      wait_strobe(n0);
      chk("first_latency", strobe_cyc - en_cyc, 3);
      chk("mid_out0", int'(last_val), 0);
      chk("mid_muted_fall", int'(last_muted), 0);
      n0 = strobe_cnt;
      for (int i = 0; i < 255; i++) send_window(16'h8000);
      repeat (8) @(posedge clk);
      chk("mid_strobes", strobe_cnt - n0, 255);
      chk("mid_spacing", spacing, WIN * 4);
      chk("mid_out_last", int'(last_val), 0);

      // step at full gain
      window_wait(16'hC000, v);
      chk("step_0", int'($signed(v)), 16384);
      window_wait(16'hC000, v);
      chk("step_1", int'($signed(v)), 16368);

      // saturation both ways
      for (int i = 0; i < 4; i++) window_wait(16'h0000, v);
      window_wait(16'hFFFF, v);
      chk("sat_pos", int'($signed(v)), 32767);
      window_wait(16'h0000, v);
      chk("sat_neg", int'($signed(v)), -32768);

      // mute ramp: 255 down to 100, release, back to full, then full mute
      mute = 1'b1;
      window_wait(16'h0000, v);
      chk("ramp_g255", int'($signed(v)), -32609);
      for (int i = 0; i < 155; i++) window_wait(16'h0000, v);
      mute = 1'b0;
      for (int i = 0; i < 156; i++) window_wait(16'h0000, v);
      mute = 1'b1;
      for (int i = 0; i < 255; i++) window_wait(16'h0000, v);
      chk("ramp_g1_muted", int'(last_muted), 0);
      window_wait(16'h0000, v);
      chk("mute_out", int'(v), 0);
      chk("mute_muted", int'(last_muted), 1);
      mute = 1'b0;

      // reset with a partial window, then with a sample in flight
      for (int i = 0; i < 5; i++) send_enable(16'hFFFF);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n0 = strobe_cnt;
      for (int i = 0; i < WIN - 1; i++) send_enable(16'h8000);
      @(posedge clk); #1 en = 1'b1; din = 16'h8000;
      @(posedge clk); #1 en = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      chk("inflight_dropped", strobe_cnt - n0, 0);
      for (int i = 0; i < 5; i++) send_enable(16'hFFFF);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      window_wait(16'h8000, v);
      chk("post_reset_out", int'(v), 0);
      for (int i = 0; i < 255; i++) window_wait(16'h8000, v);

      // volume steps on a fresh step response
      vol = 2'd0;
      window_wait(16'hC000, v);
      chk("vol0", int'($signed(v)), 2048);
      vol = 2'd1;
      window_wait(16'hC000, v);
      chk("vol1", int'($signed(v)), 4092);
      vol = 2'd2;
      window_wait(16'hC000, v);
      chk("vol2", int'($signed(v)), 8176);
      vol = 2'd3;
      window_wait(16'hC000, v);
      chk("vol3", int'($signed(v)), 16338);

      repeat (10) @(posedge clk);
      chk("queue_drained", due_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
